sym_timing_nco: RTL and testbench
=================================

# sym_timing_nco

- Symbol-timing NCO that sits directly upstream of the polyphase fractional-delay interpolator in the MSK receive path.
- Takes the 200 MHz oversampled I/Q stream and a signed timing correction from the timing loop filter.
- Produces a one-per-symbol strobe with the integer polyphase index and the fractional offset (mu).
- Forwards the I/Q samples re-timed by one cycle, so the interpolator's delay line and the strobe stay cycle-aligned.

## Interface

Parameters:
- OSF, 20, nominal samples per symbol; also the polyphase branch count.
- PH_W, 5, width of the integer phase field; must satisfy 2^PH_W ≥ OSF+2.
- MU_W, 27, width of the fractional phase field (mu).
- WIQ, 16, I/Q sample width.
- ADJ_W, 24, width of the signed correction word, in units of 2^-MU_W sample.
- FILL_LEN, 100, number of valid samples accepted before strobes are enabled (OSF × TAPS_PPH).
- ADJ_LIM, 2^22, correction magnitude limit (used only when the clamp is compiled in).

Ports:
- clk  in  1  system clock, 200 MHz.
- reset  in  1  synchronous, active-high reset.
- en_i  in  1  run enable; low forces IDLE.
- i_raw_i / q_raw_i  in  WIQ  signed oversampled samples.
- iq_raw_val_i  in  1  sample valid.
- adj_i  in  ADJ_W  signed per-sample step correction.
- adj_val_i  in  1  adj_i valid; latched on this cycle.
- i_o / q_o  out  WIQ  samples delayed 1 cycle.
- iq_val_o  out  1  iq_raw_val_i delayed 1 cycle.
- phase_int_o  out  PH_W  polyphase index, 0…OSF-1.
- mu_o  out  MU_W  fractional offset.
- sym_valid_o  out  1  symbol strobe, 1 cycle wide.
- locked_o  out  1  high in RUN.

## Operation

- Accumulator `acc` is unsigned, PH_W+1+MU_W bits, format Q(PH_W+1).MU_W in sample units. Valid range is [0, OSF).
- Step is 1.0 (that is, 2^MU_W) plus sign-extended `adj_q`. `adj_q` is a register loaded from adj_i when adj_val_i is high.
- State machine:
  - IDLE: acc = 0, fill counter = 0, no strobes. Goes to FILL when en_i = 1.
  - FILL: counts valid samples and does not advance acc. Goes to RUN on the cycle the FILL_LEN-th valid sample is accepted.
  - RUN: on each iq_raw_val_i, compute `nxt = acc + step`.
    - If nxt ≥ OSF: acc ← nxt − OSF, sym_valid_o = 1, phase_int_o = integer part of (nxt − OSF), mu_o = fractional part.
    - Otherwise acc ← nxt.
  - Any state goes to IDLE when en_i = 0 (takes effect next cycle; acc cleared).
- No valid sample (gaps): acc, fill counter and state hold, and the strobe stays low.
- A single sample never produces two wraps, because step < 2.
- adj_val_i and iq_raw_val_i asserted on the same cycle: the sample uses the old adj_q; the new value applies from the next sample.
- acc exactly reaches OSF: wrap to 0, strobe, phase_int_o = 0, mu_o = 0.
- phase_int_o and mu_o hold their value between strobes.

## Timing

- All outputs are registered.
- Latency from iq_raw_val_i to iq_val_o / sym_valid_o is 1 cycle.
- The strobe coincides with iq_val_o of the sample that caused the wrap.
- Reset values:
  - All outputs 0, including locked_o = 0.
  - State = IDLE, acc = 0, adj_q = 0, fill counter = 0.
- reset asserted mid-operation: the cycle after, everything is at reset values. A strobe pending in the output register is dropped.
- Throughput: one sample per cycle; iq_raw_val_i may be high continuously.

## Configuration

- `SYM_TIMING_NCO_CLAMP_EN` defined: adj_i is saturated to [−ADJ_LIM, +ADJ_LIM] before it is loaded into adj_q.
- Not defined: adj_i is loaded unmodified. This is safe because |adj| < 2^(ADJ_W−1) keeps step < 2.

## Structure

- Shared package `msk_timing_pkg` contains:
  - the OSF, PH_W and MU_W constants;
  - typedefs `phase_int_t` (logic [PH_W-1:0]), `mu_t` (logic [MU_W-1:0]) and `adj_t` (logic signed [ADJ_W-1:0]);
  - the state enum `nco_state_t` {IDLE, FILL, RUN}.
- The interpolator and the loop filter import the same package.
- Single module; no sub-module is warranted.

## Test plan

- **Nominal cadence:** en_i = 1, adj = 0, valid every cycle → locked_o rises after 100 samples. Strobe then every 20 samples with phase_int_o = 0 and mu_o = 0.
- **Positive correction:** adj = 2^21 (1/64 sample) from the start of RUN → first strobe on the 20th sample with phase_int_o = 0 and mu_o = 41943040 (0.3125 × 2^27).
- **Valid gaps:** iq_raw_val_i toggled 1-0-1-0 with adj = 0 → strobe every 20 valid samples, i.e. every 40 cycles; acc is unchanged in gap cycles.
- **Simultaneous update:** adj_val_i on the same cycle as a sample → that sample's step uses the old adj_q, verified against a reference accumulator.
- **Clamp:** with the macro defined, adj_i = 2^23−1 → adj_q = 2^22. Without the macro, adj_q = 2^23−1.
- **Reset mid-run:** pulse reset while in RUN → next cycle all outputs are 0 and the state is IDLE. Strobes resume only after 100 new valid samples.

Source files
------------

// File: rtl/msk_timing_pkg.sv
// msk_timing_pkg: constants, field types and NCO state shared by the MSK timing-recovery blocks
// (symbol-timing NCO, polyphase interpolator, loop filter).
package msk_timing_pkg;
    localparam int OSF   = 20;
    localparam int PH_W  = 5;
    localparam int MU_W  = 27;
    localparam int ADJ_W = 24;
    typedef logic [PH_W-1:0] phase_int_t;
    typedef logic [MU_W-1:0] mu_t;
    typedef logic signed [ADJ_W-1:0] adj_t;
    typedef enum logic [1:0] {IDLE, FILL, RUN} nco_state_t;
endpackage

// File: rtl/sym_timing_nco.sv
// sym_timing_nco: symbol-timing NCO giving a per-symbol strobe with polyphase index and mu.
// Define SYM_TIMING_NCO_CLAMP_EN to saturate adj_i to +/-ADJ_LIM before it is latched.
module sym_timing_nco #(
    parameter int OSF      = msk_timing_pkg::OSF,
    parameter int PH_W     = msk_timing_pkg::PH_W,
    parameter int MU_W     = msk_timing_pkg::MU_W,
    parameter int WIQ      = 16,
    parameter int ADJ_W    = msk_timing_pkg::ADJ_W,
    parameter int FILL_LEN = 100,
    parameter int ADJ_LIM  = 2 ** 22
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en_i,
    input  logic signed [WIQ-1:0]   i_raw_i,
    input  logic signed [WIQ-1:0]   q_raw_i,
    input  logic                    iq_raw_val_i,
    input  logic signed [ADJ_W-1:0] adj_i,
    input  logic                    adj_val_i,
    output logic signed [WIQ-1:0]   i_o,
    output logic signed [WIQ-1:0]   q_o,
    output logic                    iq_val_o,
    output logic [PH_W-1:0]         phase_int_o,
    output logic [MU_W-1:0]         mu_o,
    output logic                    sym_valid_o,
    output logic                    locked_o
);
    import msk_timing_pkg::*;

    localparam int AW = PH_W + 1 + MU_W;
    localparam int FW = $clog2(FILL_LEN + 1);
    localparam logic [AW-1:0] ONE = AW'(1) << MU_W;
    localparam logic [AW-1:0] SYM = AW'(OSF) << MU_W;

    nco_state_t              state_q, state_d;
    logic [AW-1:0]           acc_q, acc_d, step, nxt, wrapped;
    logic [FW-1:0]           fill_q, fill_d;
    logic signed [ADJ_W-1:0] adj_q, adj_d, adj_ld;
    logic                    adv, wrap, fill_done;
    logic signed [WIQ-1:0]   i_q, q_q;
    logic                    val_q, sym_q, sym_d, lock_q;
    logic [PH_W-1:0]         ph_q, ph_d;
    logic [MU_W-1:0]         mu_q, mu_d;

`ifdef SYM_TIMING_NCO_CLAMP_EN
    localparam logic signed [ADJ_W-1:0] LIM = ADJ_W'(ADJ_LIM);
    assign adj_ld = adj_i > LIM ? LIM : adj_i < -LIM ? -LIM : adj_i;
`else
    assign adj_ld = adj_i;
`endif

    // step stays below 2.0 for any adj, so one sample can wrap at most once
    assign step      = ONE + {{(AW-ADJ_W){adj_q[ADJ_W-1]}}, adj_q};
    assign nxt       = acc_q + step;
    assign wrap      = nxt >= SYM;
    assign wrapped   = nxt - SYM;
    assign adv       = en_i && state_q == RUN && iq_raw_val_i;
    assign fill_done = state_q == FILL && iq_raw_val_i && fill_q == FW'(FILL_LEN - 1);

    always_ff @(posedge clk) begin
        state_q <= reset ? IDLE : state_d;
    end

    always_comb begin
        state_d = !en_i ? IDLE : state_q == IDLE ? FILL : fill_done ? RUN : state_q;
    end

    always_comb begin
        acc_d  = !en_i || state_q != RUN ? '0 : adv ? (wrap ? wrapped : nxt) : acc_q;
        fill_d = en_i && state_q == FILL && !fill_done ? fill_q + FW'(iq_raw_val_i) : '0;
        adj_d  = adj_val_i ? adj_ld : adj_q;
        sym_d  = adv && wrap;
        ph_d   = sym_d ? wrapped[MU_W +: PH_W] : ph_q;
        mu_d   = sym_d ? wrapped[MU_W-1:0] : mu_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q  <= '0;
            fill_q <= '0;
            adj_q  <= '0;
            i_q    <= '0;
            q_q    <= '0;
            val_q  <= 1'b0;
            sym_q  <= 1'b0;
            lock_q <= 1'b0;
            ph_q   <= '0;
            mu_q   <= '0;
        end else begin
            acc_q  <= acc_d;
            fill_q <= fill_d;
            adj_q  <= adj_d;
            i_q    <= i_raw_i;
            q_q    <= q_raw_i;
            val_q  <= iq_raw_val_i;
            sym_q  <= sym_d;
            lock_q <= state_d == RUN;
            ph_q   <= ph_d;
            mu_q   <= mu_d;
        end
    end

    assign i_o         = i_q;
    assign q_o         = q_q;
    assign iq_val_o    = val_q;
    assign sym_valid_o = sym_q;
    assign phase_int_o = ph_q;
    assign mu_o        = mu_q;
    assign locked_o    = lock_q;
endmodule

// File: tb/tb_sym_timing_nco.sv
// tb_sym_timing_nco: randomized and directed bench for sym_timing_nco against a sample-unit
// reference accumulator; honours SYM_TIMING_NCO_CLAMP_EN like the design.
`timescale 1ns/1ps
module tb_sym_timing_nco;
`ifdef SYM_TIMING_NCO_CLAMP_EN
    localparam bit CLAMP = 1'b1;
`else
    localparam bit CLAMP = 1'b0;
`endif
    localparam longint ONE  = 64'd1 << 27;
    localparam longint SLEN = 20 * ONE;
    localparam longint LIM  = 64'd1 << 22;

    logic clk = 1'b0, reset = 1'b1, en = 1'b0, val = 1'b0, adj_val = 1'b0;
    logic signed [15:0] i_raw = '0, q_raw = '0, i_o, q_o;
    logic signed [23:0] adj = '0;
    logic iq_val_o, sym_valid_o, locked_o;
    logic [4:0] phase_int_o;
    logic [26:0] mu_o;

    int total = 0, bad = 0;
    bit cmp_on = 1'b0;

    sym_timing_nco dut (
        .clk(clk), .reset(reset), .en_i(en), .i_raw_i(i_raw), .q_raw_i(q_raw),
        .iq_raw_val_i(val), .adj_i(adj), .adj_val_i(adj_val), .i_o(i_o), .q_o(q_o),
        .iq_val_o(iq_val_o), .phase_int_o(phase_int_o), .mu_o(mu_o),
        .sym_valid_o(sym_valid_o), .locked_o(locked_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic longint lim(input longint a);
        return !CLAMP ? a : a > LIM ? LIM : a < -LIM ? -LIM : a;
    endfunction

    // Reference: position in sample units, advanced per accepted sample
    longint m_acc = 0, m_adj = 0, e_ph = 0, e_mu = 0;
    int m_fill = 0, m_mode = 0;
    logic signed [15:0] e_i = '0, e_q = '0;
    logic e_val = 1'b0, e_sym = 1'b0, e_lock = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_acc = 0; m_adj = 0; m_fill = 0; m_mode = 0;
            e_i = '0; e_q = '0; e_val = 0; e_sym = 0; e_lock = 0; e_ph = 0; e_mu = 0;
        end else begin
            e_i = i_raw; e_q = q_raw; e_val = val; e_sym = 0;
            if (!en) begin
                m_mode = 0; m_acc = 0; m_fill = 0;
            end else if (m_mode == 0) begin
                m_mode = 1;
            end else if (m_mode == 1) begin
                if (val) begin
                    m_fill++;
                    if (m_fill == 100) begin m_mode = 2; m_fill = 0; end
                end
            end else if (val) begin
                m_acc += ONE + m_adj;
                if (m_acc >= SLEN) begin
                    m_acc -= SLEN;
                    e_sym = 1; e_ph = m_acc / ONE; e_mu = m_acc % ONE;
                end
            end
            e_lock = m_mode == 2;
            if (adj_val) m_adj = lim(longint'(adj));
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("iq_val", iq_val_o, e_val);
            chk("i_o", i_o, e_i);
            chk("q_o", q_o, e_q);
            chk("sym_valid", sym_valid_o, e_sym);
            chk("locked", locked_o, e_lock);
            chk("phase_int", phase_int_o, e_ph);
            chk("mu", mu_o, e_mu);
        end
    end

    int nsamp = 0, ncyc = 0, lock_at = -1;
    int st_samp[$], st_cyc[$];
    longint st_ph[$], st_mu[$];

    function automatic longint qv(input longint q[$], input int i);
        return i < q.size() ? q[i] : -1;
    endfunction

    function automatic int qi(input int q[$], input int i);
        return i < q.size() ? q[i] : -1;
    endfunction

    task automatic cyc(input logic v, input logic av, input logic [23:0] a);
        val = v; adj_val = av; adj = a;
        i_raw = 16'($urandom); q_raw = 16'($urandom);
        @(posedge clk); #1;
        ncyc++;
        if (v) nsamp++;
        if (locked_o && lock_at < 0) lock_at = nsamp;
        if (sym_valid_o) begin
            st_samp.push_back(nsamp); st_cyc.push_back(ncyc);
            st_ph.push_back(longint'(phase_int_o)); st_mu.push_back(longint'(mu_o));
        end
    endtask

    task automatic clr;
        nsamp = 0; ncyc = 0; lock_at = -1;
        st_samp.delete(); st_cyc.delete(); st_ph.delete(); st_mu.delete();
    endtask

    task automatic start;
        reset = 1; en = 0; cyc(0, 0, 0);
        reset = 0; en = 1; cyc(0, 0, 0);
        clr();
    endtask

    task automatic feed(input int n, input int per);
        for (int i = 0; i < n; i++) begin
            cyc(1, 0, 0);
            for (int j = 1; j < per; j++) cyc(0, 0, 0);
        end
    endtask

    initial begin
        cyc(0, 0, 0);
        cmp_on = 1;
        cyc(0, 0, 0);
        chk("rst_sym", sym_valid_o, 0);
        chk("rst_lock", locked_o, 0);
        chk("rst_val", iq_val_o, 0);
        chk("rst_ph", phase_int_o, 0);
        chk("rst_mu", mu_o, 0);

        start();
        feed(160, 1);
        chk("nom_lock_at", lock_at, 100);
        chk("nom_nstrobe", st_samp.size(), 3);
        chk("nom_st0", qi(st_samp, 0), 120);
        chk("nom_st1", qi(st_samp, 1), 140);
        chk("nom_st2", qi(st_samp, 2), 160);
        chk("nom_ph", qv(st_ph, 0), 0);
        chk("nom_mu", qv(st_mu, 0), 0);

        feed(10, 1);
        reset = 1; cyc(1, 0, 0);
        chk("midrst_sym", sym_valid_o, 0);
        chk("midrst_lock", locked_o, 0);
        chk("midrst_val", iq_val_o, 0);
        chk("midrst_ph", phase_int_o, 0);
        chk("midrst_mu", mu_o, 0);
        reset = 0; cyc(0, 0, 0);
        clr();
        feed(125, 1);
        chk("midrst_lock_at", lock_at, 100);
        chk("midrst_st0", qi(st_samp, 0), 120);

        start();
        cyc(1, 1, 24'(1 << 21));
        feed(119, 1);
        chk("pos_st0", qi(st_samp, 0), 120);
        chk("pos_ph", qv(st_ph, 0), 0);
        chk("pos_mu", qv(st_mu, 0), 41943040);

        start();
        feed(100, 1);
        cyc(1, 1, 24'(1 << 22));
        feed(19, 1);
        chk("simul_st0", qi(st_samp, 0), 120);
        chk("simul_mu", qv(st_mu, 0), 79691776);

        start();
        cyc(1, 1, 24'h7FFFFF);
        feed(119, 1);
        chk("clamp_st0", qi(st_samp, 0), CLAMP ? 120 : 119);
        chk("clamp_mu", qv(st_mu, 0), CLAMP ? 83886080 : 25165805);

        start();
        feed(140, 2);
        chk("gap_st0", qi(st_samp, 0), 120);
        chk("gap_st1", qi(st_samp, 1), 140);
        chk("gap_period", qi(st_cyc, 1) - qi(st_cyc, 0), 40);

        start();
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 999) < 3) begin
                en = 0;
                for (int j = 0; j < int'($urandom_range(1, 4)); j++) cyc(0, $urandom_range(0, 3) == 0, 24'($urandom));
                en = 1;
            end else begin
                cyc($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, 24'($urandom));
            end
        end
        chk("rand_any_strobe", st_samp.size() > 0, 1);

        cmp_on = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
